// File: rtl/dispense_pkg.sv
// dispense_pkg: shared state encoding, widths and default timing constants for the dispense monitor
package dispense_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_PILL, DONE, MISSED} state_t;
   localparam int PILL_W = 3;
   localparam int DEBOUNCE_CYCLES_DEF = 250000;
   localparam int TIMEOUT_S_DEF = 30;
endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: 2-flop synchronizer, level debouncer and one-cycle rising-edge pulse for the beam sensor
module debounce_sync
   import dispense_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic CLOCK_50,
   input  logic resetn,
   input  logic sensor_raw,
   output logic rise
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic level, level_q;
   // resynchronize the raw input, then adopt a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         sync <= '0;
         cnt <= '0;
         level <= 1'b0;
         level_q <= 1'b0;
      end else begin
         sync <= {sync[0], sensor_raw};
         level_q <= level;
         if (sync[1] == level) cnt <= '0;
         else if (cnt == CNT_LAST) begin
            level <= sync[1];
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
   assign rise = level & ~level_q;
endmodule

// File: rtl/dispense_monitor.sv
// dispense_monitor: counts pills during a dispense window, flags timeouts and pills seen outside a dispense
module dispense_monitor
   import dispense_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int TIMEOUT_S = TIMEOUT_S_DEF
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic              dispense_req,
   input  logic [PILL_W-1:0] expected_count,
   input  logic              tick_1hz,
   input  logic              sensor_raw,
   input  logic              ack,
   output logic              busy,
   output logic              done,
   output logic              missed,
   output logic              stray,
   output logic [PILL_W-1:0] pill_count
);
   localparam int SW = $clog2(TIMEOUT_S + 1);
   localparam logic [SW-1:0] SEC_LAST = SW'(TIMEOUT_S - 1);
   state_t state, nxt;
   logic [PILL_W-1:0] expected, count_inc;
   logic [SW-1:0] sec_cnt;
   logic pill, last_pill, timeout;

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .sensor_raw(sensor_raw),
      .rise      (pill)
   );

   assign count_inc = pill_count + 1'b1;
   assign last_pill = pill && count_inc == expected;
   assign timeout = tick_1hz && sec_cnt == SEC_LAST;
   assign busy = state == WAIT_PILL;
   assign done = state == DONE;

   // next state: the final pill beats a coincident timeout; DONE and MISSED last one cycle
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = dispense_req ? (expected_count == '0 ? DONE : WAIT_PILL) : IDLE;
         WAIT_PILL: nxt = last_pill ? DONE : timeout ? MISSED : WAIT_PILL;
         default:   nxt = IDLE;
      endcase
   end

   // state, counters and sticky flags; a set condition wins over ack
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state <= IDLE;
         expected <= '0;
         pill_count <= '0;
         sec_cnt <= '0;
         missed <= 1'b0;
         stray <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && dispense_req) begin
            expected <= expected_count;
            pill_count <= '0;
            sec_cnt <= '0;
         end else if (state == WAIT_PILL) begin
            if (pill) pill_count <= (pill_count == '1) ? pill_count : count_inc;
            if (tick_1hz) sec_cnt <= sec_cnt + 1'b1;
         end
         missed <= (nxt == MISSED) | (missed & ~ack);
         stray <= (pill & (state != WAIT_PILL)) | (stray & ~ack);
      end
   end
endmodule

// File: tb/tb_dispense_monitor.sv
// tb_dispense_monitor: directed scoreboard bench; expected output vectors are queued in order and popped on each output change or probe
module tb_dispense_monitor;
   logic CLOCK_50 = 1'b0;
   logic resetn, dispense_req, tick_1hz, sensor_raw, ack;
   logic [2:0] expected_count;
   logic busy, done, missed, stray;
   logic [2:0] pill_count;
   logic probe = 1'b0, fin = 1'b0, mon_on = 1'b0, drained = 1'b0;
   logic [6:0] sb[$];
   logic [6:0] cur, prev, e;
   int total = 0, bad = 0;

   dispense_monitor #(.DEBOUNCE_CYCLES(4), .TIMEOUT_S(3)) dut (
      .CLOCK_50      (CLOCK_50),
      .resetn        (resetn),
      .dispense_req  (dispense_req),
      .expected_count(expected_count),
      .tick_1hz      (tick_1hz),
      .sensor_raw    (sensor_raw),
      .ack           (ack),
      .busy          (busy),
      .done          (done),
      .missed        (missed),
      .stray         (stray),
      .pill_count    (pill_count)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // monitor: compare on every change of {busy,done,missed,stray,pill_count} and on explicit probes
   always @(negedge CLOCK_50) begin
      cur = {busy, done, missed, stray, pill_count};
      if (probe || (mon_on && cur != prev)) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL chk%0d unexpected: got %b, nothing queued", total, cur);
         end else begin
            e = sb.pop_front();
            if (cur !== e) begin
               bad++;
               $display("FAIL chk%0d: got %b want %b (busy,done,missed,stray,count)", total, cur, e);
            end
         end
         mon_on = 1'b1;
      end
      if (fin && !drained) begin
         total++;
         if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: left %0d want 0", sb.size());
         end
         drained = 1'b1;
      end
      prev = cur;
   end

   function automatic logic [6:0] v(input logic b, d, m, s, input logic [2:0] pc);
      return {b, d, m, s, pc};
   endfunction

   task automatic ex(input logic [6:0] x);
      sb.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic do_req(input logic [2:0] n);
      dispense_req = 1'b1;
      expected_count = n;
      step(1);
      dispense_req = 1'b0;
      probe = 1'b1;
      step(1);
      probe = 1'b0;
   endtask

   task automatic pill(input int n);
      sensor_raw = 1'b1;
      step(n);
      sensor_raw = 1'b0;
      step(12);
   endtask

   task automatic tick();
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
      step(2);
   endtask

   initial begin
      resetn = 1'b0;
      dispense_req = 1'b0;
      expected_count = '0;
      tick_1hz = 1'b0;
      sensor_raw = 1'b0;
      ack = 1'b0;
      step(3);
      ex(v(0, 0, 0, 0, 0));
      probe = 1'b1;
      step(1);
      probe = 1'b0;
      // two pills complete a dispense of 2, request taken on the first edge out of reset
      ex(v(1, 0, 0, 0, 0)); ex(v(1, 0, 0, 0, 1)); ex(v(0, 1, 0, 0, 2)); ex(v(0, 0, 0, 0, 2));
      resetn = 1'b1;
      do_req(2);
      pill(10);
      pill(10);
      // timeout after three seconds with one pill, then ack clears missed
      ex(v(1, 0, 0, 0, 0)); ex(v(1, 0, 0, 0, 1)); ex(v(0, 0, 1, 0, 1)); ex(v(0, 0, 0, 0, 1));
      do_req(3);
      pill(10);
      tick(); tick(); tick();
      step(2);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      step(2);
      // short glitches are rejected, a 5-cycle pulse counts
      ex(v(1, 0, 0, 0, 0)); ex(v(1, 0, 0, 0, 1)); ex(v(0, 1, 0, 0, 2)); ex(v(0, 0, 0, 0, 2));
      do_req(2);
      repeat (2) begin
         sensor_raw = 1'b1;
         step(3);
         sensor_raw = 1'b0;
         step(8);
      end
      pill(5);
      pill(10);
      // zero-pill request completes immediately
      ex(v(0, 1, 0, 0, 0)); ex(v(0, 0, 0, 0, 0));
      do_req(0);
      step(2);
      // stray pill in idle, second request while busy is ignored
      ex(v(0, 0, 0, 1, 0));
      pill(10);
      ex(v(1, 0, 0, 1, 0)); ex(v(1, 0, 0, 1, 0));
      ex(v(1, 0, 0, 1, 1)); ex(v(0, 1, 0, 1, 2)); ex(v(0, 0, 0, 1, 2)); ex(v(0, 0, 0, 0, 2));
      do_req(2);
      do_req(1);
      pill(10);
      pill(10);
      ack = 1'b1;
      step(1);
      ack = 1'b0;
      step(1);
      // stray set wins over a held ack, then ack clears it
      ex(v(0, 0, 0, 1, 2)); ex(v(0, 0, 0, 0, 2));
      ack = 1'b1;
      pill(10);
      ack = 1'b0;
      // final pill coincident with the timeout tick: done, not missed
      ex(v(1, 0, 0, 0, 0)); ex(v(0, 1, 0, 0, 1)); ex(v(0, 0, 0, 0, 1));
      do_req(1);
      tick(); tick();
      sensor_raw = 1'b1;
      step(6);
      tick_1hz = 1'b1;
      step(1);
      tick_1hz = 1'b0;
      step(3);
      sensor_raw = 1'b0;
      step(12);
      // reset mid-dispense aborts silently; request accepted on the first edge after release
      ex(v(1, 0, 0, 0, 0)); ex(v(1, 0, 0, 0, 1)); ex(v(0, 0, 0, 0, 0));
      do_req(3);
      pill(10);
      resetn = 1'b0;
      step(2);
      ex(v(0, 1, 0, 0, 0)); ex(v(0, 0, 0, 0, 0));
      resetn = 1'b1;
      do_req(0);
      step(5);
      fin = 1'b1;
      step(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dispense_monitor.md
DISPENSE_MONITOR -- requirements
Module: dispense_monitor

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: CLOCK_50 samples every register, and resetn acts only on a CLOCK_50 rising edge.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: number of consecutive stable cycles needed to accept a sensor level (5 ms at 50 MHz).
REQ-003 Parameter TIMEOUT_S, default 30: number of seconds allowed for a dispense to finish.
REQ-004 CLOCK_50  in  1  system clock, 50 MHz.
REQ-005 resetn  in  1  synchronous reset, active low.
REQ-006 dispense_req  in  1  one-cycle pulse from the dispense-time logic that starts monitoring.
REQ-007 expected_count  in  3  pills expected for this dispense; sampled on the accepted dispense_req.
REQ-008 tick_1hz  in  1  one-cycle pulse per second (second-counter pulse).
REQ-009 sensor_raw  in  1  asynchronous GPIO beam-break input; 1 = pill in beam.
REQ-010 ack  in  1  level input, active high; clears the sticky flags.
REQ-011 busy  out  1  high while in WAIT_PILL.
REQ-012 done  out  1  one-cycle pulse when the expected count is reached.
REQ-013 missed  out  1  sticky flag: dispense timed out.
REQ-014 stray  out  1  sticky flag: a pill was detected outside a dispense.
REQ-015 pill_count  out  3  pills counted in the current or last dispense.

Function
REQ-016 sensor_raw SHALL pass through a 2-flop synchronizer before debouncing.
REQ-017 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
REQ-018 A pill event SHALL be a 0->1 transition of the debounced level, one cycle wide; latency from the sensor_raw edge is 2 + DEBOUNCE_CYCLES cycles, +/-1.
REQ-019 The FSM SHALL have the states IDLE, WAIT_PILL, DONE and MISSED.
REQ-020 IDLE -> WAIT_PILL on dispense_req with expected_count != 0; on entry pill_count := 0, seconds counter := 0, expected latched.
REQ-021 IDLE -> DONE on dispense_req with expected_count == 0; done asserts on the next cycle and pill_count := 0.
REQ-022 In WAIT_PILL, each pill event SHALL increment pill_count.
REQ-023 When pill_count+1 == expected, the FSM SHALL go to DONE.
REQ-024 In WAIT_PILL, each tick_1hz SHALL increment the seconds counter, which is not restarted by pill events.
REQ-025 When the seconds counter reaches TIMEOUT_S, the FSM SHALL go to MISSED.
REQ-026 If the final pill event and the timeout fall in the same cycle, the pill SHALL win and the FSM goes to DONE.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-028 MISSED SHALL set missed, then return to IDLE the next cycle.
REQ-029 pill_count SHALL hold its value in IDLE until the next accepted request.
REQ-030 dispense_req SHALL be ignored in WAIT_PILL, DONE and MISSED, with no queueing.
REQ-031 A pill event in IDLE, DONE or MISSED SHALL set stray and leave pill_count unchanged.
REQ-032 pill_count SHALL saturate at 7.
REQ-033 ack high SHALL clear missed and stray; a set condition in the same cycle SHALL take priority over ack.

Reset
REQ-034 While resetn = 0 at a clock edge: state := IDLE; busy = done = missed = stray = 0; pill_count := 0; the synchronizer, debounced level and both counters := 0.
REQ-035 Reset mid-WAIT_PILL SHALL abort the dispense with no done or missed asserted.
REQ-036 The first clock edge after resetn rises SHALL accept dispense_req.

Structure
REQ-037 Shared package dispense_pkg SHALL hold the state enum (IDLE, WAIT_PILL, DONE, MISSED), the pill-count width (3) and the DEBOUNCE_CYCLES and TIMEOUT_S default constants.
REQ-038 Sub-module debounce_sync (synchronizer + debouncer + rising-edge pulse) SHALL be instantiated once; the FSM and counters stay in dispense_monitor.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_S=3)
REQ-039 Request with expected=2, then two clean 10-cycle sensor pulses -> pill_count 1 then 2, done pulses once, busy falls, missed=0.
REQ-040 Request with expected=3, one pill, then 3 tick_1hz pulses -> missed=1, pill_count=1, no done; ack -> missed=0.
REQ-041 sensor_raw glitches of 3 cycles during WAIT_PILL -> pill_count stays 0; a 5-cycle pulse -> pill_count=1.
REQ-042 Request with expected=0 -> done on the next cycle, busy never high.
REQ-043 Pill in IDLE -> stray=1, pill_count unchanged; a second dispense_req while busy -> ignored, latched expected unchanged.
REQ-044 Final pill event coincident with the 3rd tick -> done=1, missed=0; resetn low mid-WAIT_PILL -> all outputs 0, state IDLE.
